// File: rtl/issue_rr_arbiter_if.sv
// Issue-slot arbitration bus: wavefront request/mask flags in, registered grant out.
// The lock input exists only when ISSUE_ARB_LOCK_EN is defined.
interface issue_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 40,
    parameter int unsigned ID_W    = 6
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_mask;
    logic               grant_accept;
`ifdef ISSUE_ARB_LOCK_EN
    logic               lock;
`endif
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_onehot;

    // Arbiter side: consumes requests, drives the grant.
    modport master (
        input  req,
        input  req_mask,
        input  grant_accept,
`ifdef ISSUE_ARB_LOCK_EN
        input  lock,
`endif
        output grant_valid,
        output grant_id,
        output grant_onehot
    );

    // Requester / issue-stage side.
    modport slave (
        output req,
        output req_mask,
        output grant_accept,
`ifdef ISSUE_ARB_LOCK_EN
        output lock,
`endif
        input  grant_valid,
        input  grant_id,
        input  grant_onehot
    );
endinterface

// File: rtl/issue_rr_arbiter.sv
// Registered round-robin arbiter for the compute-unit issue slot.
// A grant is held until accepted; priority then rotates past the accepted id.
// Optional feature macro: ISSUE_ARB_LOCK_EN (adds lock input for back-to-back
// re-grant of the same wavefront for multi-dword instructions).
module issue_rr_arbiter #(
    parameter int unsigned NUM_REQ = 40,
    parameter int unsigned ID_W    = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    issue_rr_arbiter_if.master     io_bus
);

    typedef enum logic {StIdle, StHold} state_e;

    state_e             r_state;
    logic [ID_W-1:0]    r_grant_id;
    logic [NUM_REQ-1:0] r_grant_onehot;
    logic [ID_W-1:0]    r_ptr;

    state_e             w_state_d;
    logic               w_grant_en;
    logic [ID_W-1:0]    w_grant_id_d;
    logic [NUM_REQ-1:0] w_grant_onehot_d;
    logic               w_ptr_en;
    logic               w_accept;
    logic               w_rotate;

    logic [NUM_REQ-1:0] w_elig;
    logic [ID_W-1:0]    w_search_ptr;
    logic [NUM_REQ-1:0] w_hi_mask;
    logic [NUM_REQ-1:0] w_elig_hi;
    logic               w_win_any;
    logic [ID_W-1:0]    w_win_id;
    logic [NUM_REQ-1:0] w_win_onehot;

`ifdef ISSUE_ARB_LOCK_EN
    logic               r_lock;
    logic               w_lock_d;
    logic               w_lock_hit;
`endif

    // Lowest set index of a vector (zero when the vector is empty).
    function automatic logic [ID_W-1:0] f_lowest(input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    assign w_elig   = io_bus.req & ~io_bus.req_mask;
    assign w_accept = (r_state == StHold) && io_bus.grant_accept;

    // On accept the search starts past the id being accepted, i.e. the new ptr.
    assign w_search_ptr = w_accept ? r_grant_id : r_ptr;

`ifdef ISSUE_ARB_LOCK_EN
    assign w_lock_hit = io_bus.lock && ((w_elig & r_grant_onehot) != '0);
`endif

    // Winner search: first eligible above ptr, otherwise first eligible from 0 (wrap).
    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_hi_mask[i] = (ID_W'(i) > w_search_ptr);
        end
        w_elig_hi    = w_elig & w_hi_mask;
        w_win_any    = (w_elig != '0);
        w_win_id     = (w_elig_hi != '0) ? f_lowest(w_elig_hi) : f_lowest(w_elig);
        w_win_onehot = NUM_REQ'(1) << w_win_id;
    end

    // Next-state and register enables for the IDLE/HOLD grant FSM.
    always_comb begin
        w_state_d        = r_state;
        w_grant_en       = 1'b0;
        w_grant_id_d     = r_grant_id;
        w_grant_onehot_d = r_grant_onehot;
        w_ptr_en         = 1'b0;
        w_rotate         = 1'b0;
`ifdef ISSUE_ARB_LOCK_EN
        w_lock_d         = r_lock;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_win_any) begin
                    w_grant_en       = 1'b1;
                    w_grant_id_d     = w_win_id;
                    w_grant_onehot_d = w_win_onehot;
                    w_state_d        = StHold;
                end
            end
            StHold: begin
                if (io_bus.grant_accept) begin
`ifdef ISSUE_ARB_LOCK_EN
                    // Locked re-grant keeps the current grant and ptr untouched.
                    if (w_lock_hit) begin
                        w_lock_d = 1'b1;
                    end else begin
                        w_lock_d = 1'b0;
                        w_rotate = 1'b1;
                    end
`else
                    w_rotate = 1'b1;
`endif
                end
                if (w_rotate) begin
                    w_ptr_en   = 1'b1;
                    w_grant_en = 1'b1;
                    if (w_win_any) begin
                        w_grant_id_d     = w_win_id;
                        w_grant_onehot_d = w_win_onehot;
                    end else begin
                        w_grant_id_d     = '0;
                        w_grant_onehot_d = '0;
                        w_state_d        = StIdle;
                    end
                end
            end
        endcase
    end

    // State and enable-gated grant/pointer registers; reset wins over everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_grant_id     <= '0;
            r_grant_onehot <= '0;
            r_ptr          <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_d;
            if (w_grant_en) begin
                r_grant_id     <= w_grant_id_d;
                r_grant_onehot <= w_grant_onehot_d;
            end
            if (w_ptr_en) begin
                r_ptr <= r_grant_id;
            end
        end
    end

`ifdef ISSUE_ARB_LOCK_EN
    // Sticky lock flag: set by a locked re-grant, cleared by normal rotation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= w_lock_d;
        end
    end
`endif

    assign io_bus.grant_valid  = (r_state == StHold);
    assign io_bus.grant_id     = r_grant_id;
    assign io_bus.grant_onehot = r_grant_onehot;

endmodule

// File: tb/tb_issue_rr_arbiter.sv
// Self-checking bench for issue_rr_arbiter: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_issue_rr_arbiter;

    localparam int NUM_REQ = 40;
    localparam int ID_W    = 6;

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] mask_v;
    logic               acc_v;
    logic               lock_v;

    int n_checks;
    int n_errors;

    // Behavioural model state.
    bit m_valid;
    int m_id;
    int m_ptr;

    issue_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    assign bus.req          = req_v;
    assign bus.req_mask     = mask_v;
    assign bus.grant_accept = acc_v;
`ifdef ISSUE_ARB_LOCK_EN
    assign bus.lock         = lock_v;
`endif

    issue_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin pick: scan ptr+1, ptr+2, ... modulo NUM_REQ; -1 if nothing eligible.
    function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] e);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (e[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_onehot();
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (m_valid) v[m_id] = 1'b1;
        return v;
    endfunction

    // Advance model by one clock using the inputs currently applied, then step the DUT.
    task automatic tick();
        logic [NUM_REQ-1:0] e;
        int  w;
        bit  lock_hit;
        e        = req_v & ~mask_v;
        lock_hit = 1'b0;
`ifdef ISSUE_ARB_LOCK_EN
        lock_hit = lock_v && e[m_id];
`endif
        if (rst) begin
            m_valid = 0;
            m_id    = 0;
            m_ptr   = NUM_REQ - 1;
        end else if (!m_valid) begin
            w = rr_pick(m_ptr, e);
            if (w >= 0) begin
                m_valid = 1;
                m_id    = w;
            end
        end else if (acc_v && !lock_hit) begin
            m_ptr = m_id;
            w     = rr_pick(m_ptr, e);
            if (w >= 0) begin
                m_id = w;
            end else begin
                m_valid = 0;
                m_id    = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_v  = '0;
        mask_v = '0;
        acc_v  = 1'b0;
        lock_v = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req_v  = '1;
        mask_v = '0;
        acc_v  = 1'b1;
        lock_v = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.grant_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %0b want 0", bus.grant_valid);
        end
        n_checks++;
        if (bus.grant_id !== '0) begin
            n_errors++;
            $display("FAIL reset_id: got %0d want 0", bus.grant_id);
        end
        n_checks++;
        if (bus.grant_onehot !== '0) begin
            n_errors++;
            $display("FAIL reset_onehot: got %h want 0", bus.grant_onehot);
        end
    endtask

    task automatic test_round_robin();
        int cnt [NUM_REQ];
        int bad;
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        rst   = 1'b0;
        req_v = '1;
        acc_v = 1'b1;
        for (int k = 0; k <= NUM_REQ; k++) begin
            tick();
            n_checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_W'(k % NUM_REQ)) begin
                n_errors++;
                $display("FAIL rr_seq[%0d]: got valid=%0b id=%0d want valid=1 id=%0d",
                         k, bus.grant_valid, bus.grant_id, k % NUM_REQ);
            end
            n_checks++;
            if (bus.grant_onehot !== exp_onehot()) begin
                n_errors++;
                $display("FAIL rr_onehot[%0d]: got %h want %h", k, bus.grant_onehot,
                         exp_onehot());
            end
            if (k < NUM_REQ && bus.grant_id < NUM_REQ) cnt[bus.grant_id]++;
        end
        bad = 0;
        for (int i = 0; i < NUM_REQ; i++) if (cnt[i] != 1) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL rr_fairness: got %0d ids not granted exactly once want 0", bad);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req_v    = '0;
        req_v[5] = 1'b1;
        req_v[9] = 1'b1;
        acc_v    = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req_v[5] = 1'b0;
            tick();
            n_checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_W'(5)
                || bus.grant_onehot !== (NUM_REQ'(1) << 5)) begin
                n_errors++;
                $display("FAIL hold[%0d]: got valid=%0b id=%0d oh=%h want valid=1 id=5", c,
                         bus.grant_valid, bus.grant_id, bus.grant_onehot);
            end
        end
        acc_v = 1'b1;
        tick();
        acc_v = 1'b0;
        n_checks++;
        if (bus.grant_id !== ID_W'(9) || bus.grant_id !== ID_W'(m_id)) begin
            n_errors++;
            $display("FAIL hold_next: got %0d want 9", bus.grant_id);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_v     = '0;
        req_v[38] = 1'b1;
        tick();
        req_v     = '0;
        req_v[3]  = 1'b1;
        req_v[39] = 1'b1;
        acc_v     = 1'b1;
        tick();
        n_checks++;
        if (bus.grant_id !== ID_W'(39)) begin
            n_errors++;
            $display("FAIL wrap_39: got %0d want 39", bus.grant_id);
        end
        tick();
        acc_v = 1'b0;
        n_checks++;
        if (bus.grant_id !== ID_W'(3) || bus.grant_onehot !== exp_onehot()) begin
            n_errors++;
            $display("FAIL wrap_3: got id=%0d oh=%h want id=3 oh=%h", bus.grant_id,
                     bus.grant_onehot, exp_onehot());
        end
    endtask

    task automatic test_mask_idle();
        do_reset();
        req_v     = '0;
        req_v[7]  = 1'b1;
        mask_v    = '0;
        mask_v[7] = 1'b1;
        acc_v     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== '0) begin
                n_errors++;
                $display("FAIL masked_idle[%0d]: got valid=%0b oh=%h want 0", c,
                         bus.grant_valid, bus.grant_onehot);
            end
        end
        mask_v = '0;
        tick();
        n_checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== ID_W'(7)) begin
            n_errors++;
            $display("FAIL unmask: got valid=%0b id=%0d want valid=1 id=7", bus.grant_valid,
                     bus.grant_id);
        end
        req_v = '0;
        tick();
        acc_v = 1'b0;
        n_checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== '0) begin
            n_errors++;
            $display("FAIL drain_idle: got valid=%0b oh=%h want 0", bus.grant_valid,
                     bus.grant_onehot);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_v     = '0;
        req_v[12] = 1'b1;
        tick();
        n_checks++;
        if (bus.grant_id !== ID_W'(12)) begin
            n_errors++;
            $display("FAIL mid_setup: got %0d want 12", bus.grant_id);
        end
        req_v = '1;
        acc_v = 1'b1;
        rst   = 1'b1;
        tick();
        n_checks++;
        if (bus.grant_valid !== 1'b0 || bus.grant_id !== '0 || bus.grant_onehot !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%0b id=%0d oh=%h want all 0", bus.grant_valid,
                     bus.grant_id, bus.grant_onehot);
        end
        rst   = 1'b0;
        acc_v = 1'b0;
        tick();
        n_checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== '0) begin
            n_errors++;
            $display("FAIL mid_after: got valid=%0b id=%0d want valid=1 id=0", bus.grant_valid,
                     bus.grant_id);
        end
    endtask

`ifdef ISSUE_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req_v    = '0;
        req_v[4] = 1'b1;
        req_v[6] = 1'b1;
        tick();
        acc_v  = 1'b1;
        lock_v = 1'b1;
        tick();
        n_checks++;
        if (bus.grant_id !== ID_W'(4) || bus.grant_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL lock_regrant: got %0d want 4", bus.grant_id);
        end
        lock_v = 1'b0;
        tick();
        n_checks++;
        if (bus.grant_id !== ID_W'(6)) begin
            n_errors++;
            $display("FAIL lock_release: got %0d want 6", bus.grant_id);
        end
        // Locked id no longer eligible: rotation proceeds.
        lock_v   = 1'b1;
        req_v[6] = 1'b0;
        tick();
        acc_v  = 1'b0;
        lock_v = 1'b0;
        n_checks++;
        if (bus.grant_id !== ID_W'(4)) begin
            n_errors++;
            $display("FAIL lock_inelig: got %0d want 4", bus.grant_id);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: req_v = '0;
                1: begin
                    req_v = '0;
                    req_v[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
                end
                2: req_v = NUM_REQ'({$urandom(), $urandom()});
                default: req_v = '1;
            endcase
            mask_v = NUM_REQ'({$urandom(), $urandom()} & {$urandom(), $urandom()});
            acc_v  = ($urandom_range(0, 3) != 0);
            lock_v = ($urandom_range(0, 2) == 0);
            rst    = ($urandom_range(0, 63) == 0);
            tick();
            n_checks++;
            if (bus.grant_valid !== m_valid || bus.grant_id !== ID_W'(m_id)
                || bus.grant_onehot !== exp_onehot()) begin
                n_errors++;
                $display("FAIL random[%0d]: got valid=%0b id=%0d oh=%h want valid=%0b id=%0d oh=%h",
                         n, bus.grant_valid, bus.grant_id, bus.grant_onehot, m_valid, m_id,
                         exp_onehot());
            end
        end
        rst    = 1'b0;
        acc_v  = 1'b0;
        lock_v = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_valid  = 0;
        m_id     = 0;
        m_ptr    = NUM_REQ - 1;
        rst      = 1'b1;
        req_v    = '0;
        mask_v   = '0;
        acc_v    = 1'b0;
        lock_v   = 1'b0;
        test_reset();
        test_round_robin();
        test_hold();
        test_wrap();
        test_mask_idle();
        test_reset_mid();
`ifdef ISSUE_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_rr_arbiter.md
# issue_rr_arbiter

Registered round-robin arbiter that shares the single issue slot of the compute unit among up to NUM_REQ wavefront requesters. Each cycle it samples per-wavefront request bits and presents one registered grant (id plus one-hot) to the downstream issue stage. The grant is held stable until the consumer accepts it, then priority rotates past the accepted requester. It sits between the wavefront ready/valid flags and the issue mux, and its held-state registers use enable-gated flops.

## Interface
- NUM_REQ, 40, number of requesters (wavefront slots); 2..64
- ID_W, 6, width of grant_id; must satisfy 2^ID_W >= NUM_REQ
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request; bit i = wavefront i ready to issue
- req_mask  input  NUM_REQ  1 = requester i is blocked this cycle and is excluded from arbitration
- grant_accept  input  1  downstream consumes the current grant this cycle
- grant_valid  output  1  registered; a grant is being presented
- grant_id  output  ID_W  registered; index of the granted requester
- grant_onehot  output  NUM_REQ  registered; one-hot of grant_id; all zero when grant_valid=0
- lock  input  1  only present with ARB_LOCK_EN; see Configuration

## Operation
- Eligible vector: elig = req & ~req_mask.
- Internal pointer ptr (ID_W bits) holds the last accepted id.
- Arbitration search order: ptr+1, ptr+2, …, NUM_REQ-1, 0, …, ptr. Index NUM_REQ-1 wraps to 0. ptr itself has lowest priority.
- Two states:
  - IDLE (grant_valid=0): every cycle, if elig != 0, load the winner into grant_id/grant_onehot and set grant_valid, giving HOLD. Otherwise stay in IDLE.
  - HOLD (grant_valid=1):
    - grant_accept=0: all grant outputs are frozen (enable deasserted), even if req or req_mask for the granted id drops. The grant is not revoked.
    - grant_accept=1: ptr <= grant_id. In the same cycle, compute a winner from elig using the new ptr value (the accepted id is lowest priority).
    - Accept with any eligible requester: load the new winner and stay in HOLD (back-to-back, no bubble).
    - Accept with none eligible: go to IDLE.
- grant_accept while grant_valid=0 is ignored: no state or ptr change.
- Only the arbitrated winner of the cycle can ever be granted. There is no combinational path from req to any output.

## Timing
- Reset: grant_valid=0, grant_id=0, grant_onehot=0, ptr=NUM_REQ-1, so requester 0 has highest priority after reset. With ARB_LOCK_EN, the internal lock flag is also 0.
- rst takes precedence over grant_accept and req. Reset mid-HOLD drops the grant on the next edge, and the grant is not re-presented.
- Latency: req sampled at edge N gives a grant visible after edge N (cycle N+1). Accept at cycle M gives the next grant visible in cycle M+1.
- Sustained throughput: one grant per cycle when grant_accept is tied high and any eligible requester exists.
- Fairness: with all NUM_REQ requesting continuously and accept held high, every requester is granted exactly once per NUM_REQ grants.

## Configuration
- Macro: ISSUE_ARB_LOCK_EN.
- Defined:
  - The lock input exists.
  - If lock=1 in the accept cycle and the granted id is still in elig, the next grant is the same id. ptr is not advanced, and a sticky lock flag is set.
  - If the locked id is no longer eligible, or lock=0 at accept, normal rotation resumes from the current ptr. Normal rotation also clears the lock flag.
  - Used for multi-dword instructions that must issue on consecutive slots.
- Undefined: no lock port and pure round-robin as described above. Any lock-related logic is removed.

## Test plan
- Reset priority: rst for 2 cycles, then req=all ones, grant_accept=1 → grants 0,1,2,…,39,0 on consecutive cycles. grant_valid=1 from cycle 1 after reset release.
- Hold/stall: req bits 5 and 9 set, grant_accept=0 for 4 cycles, then drop req[5] → grant_id stays 5 and grant_onehot=1<<5 throughout. Accept → next cycle grant_id=9.
- Wrap-around: ptr=38 after accepting 38, req bits 3 and 39 set → grant 39, then after accept grant 3 (wraps past 0).
- Masking/idle: req bit 7 set with req_mask bit 7 set → grant_valid stays 0. Clear the mask → grant_id=7 one cycle later. Accept with req=0 → grant_valid=0 and grant_onehot=0.
- Reset mid-operation: in HOLD with grant_id=12, assert rst and grant_accept in the same cycle → next cycle grant_valid=0, grant_id=0, and ptr=39. Next requester 0 wins.
- Lock (ISSUE_ARB_LOCK_EN): req bits 4 and 6 set, grant 4 accepted with lock=1 → grant 4 again. Accept with lock=0 → grant 6.
